cc_miss_req_scheduler: RTL and testbench
========================================

CC_MISS_REQ_SCHEDULER -- requirements
Module: CC_MISS_REQ_SCHEDULER

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of line fills in flight (legal range 1..7).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- miss_req_valid_i  in  1  miss request valid.
- miss_req_addr_i  in  32  miss byte address.
- miss_req_ready_o  out  1  miss request accepted this cycle when high with valid.
- mem_arvalid_o  out  1  AXI AR valid.
- mem_araddr_o  out  32  AXI AR address.
- mem_arlen_o  out  4  AXI AR length (beats-1).
- mem_arsize_o  out  3  AXI AR size.
- mem_arburst_o  out  2  AXI AR burst type.
- mem_arready_i  in  1  AXI AR ready.
- mem_rvalid_i  in  1  AXI R valid (observe only).
- mem_rready_i  in  1  AXI R ready (observe only).
- mem_rlast_i  in  1  AXI R last (observe only).
- miss_addr_fifo_full_i  in  1  miss-address FIFO full.
- miss_addr_fifo_wren_o  out  1  miss-address FIFO push.
- miss_addr_fifo_wdata_o  out  32  miss-address FIFO push data.
- outstanding_o  out  3  fills accepted but not yet completed.
- idle_o  out  1  no fill in flight and no AR pending.
- err_o  out  1  sticky protocol error.

Function
REQ-003 SHALL implement FSM states IDLE and ISSUE; IDLE -> ISSUE on request acceptance; ISSUE -> IDLE on mem_arvalid_o & mem_arready_i.
REQ-004 SHALL drive miss_req_ready_o = (state==IDLE) & !miss_addr_fifo_full_i & (outstanding_o < MAX_OUTSTANDING), combinationally.
REQ-005 SHALL, on acceptance, latch miss_req_addr_i and, in the same cycle, assert miss_addr_fifo_wren_o for one cycle with miss_addr_fifo_wdata_o = miss_req_addr_i.
REQ-006 SHALL assert mem_arvalid_o for every cycle in ISSUE, starting the cycle after acceptance, with all AR fields held stable until arready.
REQ-007 SHALL drive mem_arlen_o=7, mem_arsize_o=3 (8 bytes) constant, giving a 64-byte line in 8 beats.
REQ-008 SHALL increment outstanding_o on acceptance and decrement it on mem_rvalid_i & mem_rready_i & mem_rlast_i; both in one cycle SHALL leave it unchanged.
REQ-009 SHALL saturate outstanding_o at 0 on a decrement without an increment and SHALL set err_o; err_o clears only on reset.
REQ-010 SHALL drive idle_o = (state==IDLE) & (outstanding_o==0).
REQ-011 SHALL keep miss_addr_fifo_wren_o low whenever miss_req_ready_o is low, so pushes never occur on a full FIFO.

Reset
REQ-012 SHALL on reset force state=IDLE, outstanding_o=0, err_o=0, mem_arvalid_o=0, miss_addr_fifo_wren_o=0, and latched address=0.
REQ-013 SHALL abandon an AR held in ISSUE if reset asserts mid-handshake; no AR SHALL be reissued after reset.

Configuration
REQ-014 SHALL, with CC_AR_LINE_ALIGN_EN defined, drive mem_araddr_o = {addr[31:6],6'b0} with mem_arburst_o=INCR (2'b01).
REQ-015 SHALL, without CC_AR_LINE_ALIGN_EN, drive mem_araddr_o = {addr[31:3],3'b0} with mem_arburst_o=WRAP (2'b10), for critical-word-first fill.

Structure
REQ-016 SHALL take the FSM state enum, AXI burst encodings (INCR, WRAP), CC_LINE_BEATS=8 and CC_BEAT_SIZE=3 from shared package CC_PKG.
REQ-017 SHALL place the outstanding up/down counter, including saturation and err_o, in sub-module CC_OUTSTANDING_CNT.

Verification
REQ-018 Single miss: addr 0x0000_1238, arready=1 -> FIFO push 0x0000_1238 in cycle 0; AR in cycle 1 with araddr 0x0000_1238 and WRAP (macro off) or 0x0000_1200 and INCR (macro on), arlen=7; outstanding=1; after the 8th beat with rlast, outstanding=0 and idle_o=1.
REQ-019 Limit: 5 back-to-back misses with no R traffic and MAX_OUTSTANDING=4 -> 4 accepted, ready low on the 5th; one rlast -> 5th accepted.
REQ-020 FIFO full: miss_addr_fifo_full_i=1 with valid=1 -> ready=0 and wren=0; full released -> acceptance next cycle.
REQ-021 AR backpressure: arready low for 3 cycles -> arvalid and araddr stable, ready=0 throughout; handshake in cycle 4 -> IDLE.
REQ-022 Simultaneous events: acceptance and rlast in the same cycle at outstanding=2 -> outstanding stays 2; spurious rlast at 0 -> outstanding stays 0 and err_o=1.
REQ-023 Reset in ISSUE -> arvalid=0 and outstanding=0 the next cycle, with no further AR.

Source files
------------

// File: rtl/cc_miss_req_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// cc_pkg
// Shared definitions for the cache-miss request scheduler:
//   - cc_state_e      : scheduler FSM state (IDLE / ISSUE)
//   - CC_BURST_INCR/WRAP : AXI AR burst encodings
//   - CC_LINE_BEATS   : beats per line fill (8)
//   - CC_BEAT_SIZE    : AXI size code per beat (3 = 8 bytes)
//   - cc_ar_addr()    : AR address formation for either burst style
// ----------------------------------------------------------------------------
package cc_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } cc_state_e;

    localparam logic [1:0]  CC_BURST_INCR = 2'b01;
    localparam logic [1:0]  CC_BURST_WRAP = 2'b10;
    localparam int unsigned CC_LINE_BEATS = 8;
    localparam logic [2:0]  CC_BEAT_SIZE  = 3'd3;
    localparam logic [3:0]  CC_AR_LEN     = 4'(CC_LINE_BEATS - 1);

    // Line-aligned start for INCR fills, beat-aligned start for WRAP
    // (critical-word-first) fills.
    function automatic logic [31:0] cc_ar_addr(input logic [31:0] addr,
                                               input logic        line_align);
        logic [31:0] result;
        if (line_align) begin
            result = {addr[31:6], 6'b00_0000};
        end else begin
            result = {addr[31:3], 3'b000};
        end
        return result;
    endfunction

endpackage

// File: rtl/cc_miss_req_scheduler_cnt.sv
// ----------------------------------------------------------------------------
// cc_outstanding_cnt
// Up/down counter of line fills in flight, with zero saturation and a sticky
// error flag raised by a completion that has no fill to retire.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   inc_i    : a fill was accepted this cycle
//   dec_i    : a fill completed this cycle (R last beat handshake)
//   count_o  : fills in flight
//   err_o    : sticky underflow error, cleared only by reset
// ----------------------------------------------------------------------------
module cc_outstanding_cnt
    import cc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [2:0] count_o,
    output logic       err_o
);

    logic [2:0] count_q;
    logic [2:0] count_d;
    logic       err_q;
    logic       err_d;

    // Next-state count and error; simultaneous inc and dec cancel out.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        case ({inc_i, dec_i})
            2'b10: begin
                count_d = count_q + 3'd1;
            end
            2'b01: begin
                if (count_q == 3'd0) begin
                    err_d = 1'b1;
                end else begin
                    count_d = count_q - 3'd1;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Counter and error state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: rtl/cc_miss_req_scheduler.sv
// ----------------------------------------------------------------------------
// cc_miss_req_scheduler
// Accepts cache-miss requests, pushes the miss address into the miss-address
// FIFO, and issues one 8-beat AXI read burst per miss, tracking how many line
// fills are in flight.
// Configuration macro:
//   CC_AR_LINE_ALIGN_EN defined  : line-aligned address, INCR burst
//   CC_AR_LINE_ALIGN_EN undefined: beat-aligned address, WRAP burst
//                                  (critical word first)
// Ports:
//   clk, rst_n                    : clock, synchronous active-low reset
//   miss_req_valid/addr/ready     : miss request handshake
//   mem_ar*                       : AXI read-address channel
//   mem_rvalid/rready/rlast_i     : AXI R channel, observed for completion
//   miss_addr_fifo_full/wren/wdata: miss-address FIFO push port
//   outstanding_o, idle_o, err_o  : status
// ----------------------------------------------------------------------------
module cc_miss_req_scheduler
    import cc_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_req_valid_i,
    input  logic [31:0] miss_req_addr_i,
    output logic        miss_req_ready_o,
    output logic        mem_arvalid_o,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    input  logic        mem_arready_i,
    input  logic        mem_rvalid_i,
    input  logic        mem_rready_i,
    input  logic        mem_rlast_i,
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o,
    output logic [2:0]  outstanding_o,
    output logic        idle_o,
    output logic        err_o
);

`ifdef CC_AR_LINE_ALIGN_EN
    localparam logic       LINE_ALIGN = 1'b1;
    localparam logic [1:0] AR_BURST   = CC_BURST_INCR;
`else
    localparam logic       LINE_ALIGN = 1'b0;
    localparam logic [1:0] AR_BURST   = CC_BURST_WRAP;
`endif

    cc_state_e   state_q;
    cc_state_e   state_d;
    logic [31:0] addr_q;
    logic [31:0] addr_d;
    logic        accept_s;
    logic        fill_done_s;
    logic [2:0]  outstanding_s;

    // Ready is held low during reset so no push can escape while the state
    // register is still being forced to IDLE.
    assign miss_req_ready_o = rst_n
                            & (state_q == ST_IDLE)
                            & ~miss_addr_fifo_full_i
                            & ({1'b0, outstanding_s} < 4'(MAX_OUTSTANDING));
    assign accept_s    = miss_req_valid_i & miss_req_ready_o;
    assign fill_done_s = mem_rvalid_i & mem_rready_i & mem_rlast_i;

    // FSM next state and address capture.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_ISSUE;
                    addr_d  = miss_req_addr_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_arready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and latched miss address; reset abandons any pending AR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    cc_outstanding_cnt u_outstanding_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (accept_s),
        .dec_i   (fill_done_s),
        .count_o (outstanding_s),
        .err_o   (err_o)
    );

    // AR fields come straight from registered state, so they stay stable
    // for the whole ISSUE period.
    assign mem_arvalid_o = (state_q == ST_ISSUE);
    assign mem_araddr_o  = cc_ar_addr(addr_q, LINE_ALIGN);
    assign mem_arlen_o   = CC_AR_LEN;
    assign mem_arsize_o  = CC_BEAT_SIZE;
    assign mem_arburst_o = AR_BURST;

    assign miss_addr_fifo_wren_o  = accept_s;
    assign miss_addr_fifo_wdata_o = miss_req_addr_i;

    assign outstanding_o = outstanding_s;
    assign idle_o        = (state_q == ST_IDLE) & (outstanding_s == 3'd0);

endmodule

// File: tb/tb_cc_miss_req_scheduler.sv
module tb_cc_miss_req_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_req_valid_i;
    logic [31:0] miss_req_addr_i;
    logic        miss_req_ready_o;
    logic        mem_arvalid_o;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;
    logic        mem_arready_i;
    logic        mem_rvalid_i;
    logic        mem_rready_i;
    logic        mem_rlast_i;
    logic        miss_addr_fifo_full_i;
    logic        miss_addr_fifo_wren_o;
    logic [31:0] miss_addr_fifo_wdata_o;
    logic [2:0]  outstanding_o;
    logic        idle_o;
    logic        err_o;

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef CC_AR_LINE_ALIGN_EN
    localparam logic [31:0] EXP_ADDR_1238 = 32'h0000_1200;
    localparam logic [31:0] EXP_ADDR_0FF8 = 32'h8000_0FC0;
    localparam logic [1:0]  EXP_BURST     = 2'b01;
`else
    localparam logic [31:0] EXP_ADDR_1238 = 32'h0000_1238;
    localparam logic [31:0] EXP_ADDR_0FF8 = 32'h8000_0FF8;
    localparam logic [1:0]  EXP_BURST     = 2'b10;
`endif

    always #5 clk = ~clk;

    cc_miss_req_scheduler #(.MAX_OUTSTANDING(4)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miss_req_valid_i       (miss_req_valid_i),
        .miss_req_addr_i        (miss_req_addr_i),
        .miss_req_ready_o       (miss_req_ready_o),
        .mem_arvalid_o          (mem_arvalid_o),
        .mem_araddr_o           (mem_araddr_o),
        .mem_arlen_o            (mem_arlen_o),
        .mem_arsize_o           (mem_arsize_o),
        .mem_arburst_o          (mem_arburst_o),
        .mem_arready_i          (mem_arready_i),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rready_i           (mem_rready_i),
        .mem_rlast_i            (mem_rlast_i),
        .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
        .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
        .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
        .outstanding_o          (outstanding_o),
        .idle_o                 (idle_o),
        .err_o                  (err_o)
    );

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after it, then settle for a further unit.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        miss_req_valid_i = 1'b0;
        miss_req_addr_i = 32'h0;
        mem_arready_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i = 1'b0;
        miss_addr_fifo_full_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        miss_req_valid_i = 1'b1;
        miss_req_addr_i = 32'h1234_5678;
        mem_arready_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i = 1'b0;
        miss_addr_fifo_full_i = 1'b0;
        tick();
        tick();
        settle();
        total_cnt++; if (mem_arvalid_o !== 1'b0) $display("FAIL reset_arvalid got %b want 0", mem_arvalid_o); else pass_cnt++;
        total_cnt++; if (miss_addr_fifo_wren_o !== 1'b0) $display("FAIL reset_wren got %b want 0", miss_addr_fifo_wren_o); else pass_cnt++;
        total_cnt++; if (outstanding_o !== 3'd0) $display("FAIL reset_outstanding got %0d want 0", outstanding_o); else pass_cnt++;
        total_cnt++; if (err_o !== 1'b0) $display("FAIL reset_err got %b want 0", err_o); else pass_cnt++;
        total_cnt++; if (idle_o !== 1'b1) $display("FAIL reset_idle got %b want 1", idle_o); else pass_cnt++;
        total_cnt++; if (mem_araddr_o !== 32'h0) $display("FAIL reset_araddr got %h want 0", mem_araddr_o); else pass_cnt++;
        miss_req_valid_i = 1'b0;
        rst_n = 1'b1;
        settle();
        total_cnt++; if (miss_req_ready_o !== 1'b1) $display("FAIL post_reset_ready got %b want 1", miss_req_ready_o); else pass_cnt++;
    endtask

    task automatic test_single_miss();
        do_reset();
        mem_arready_i = 1'b1;
        miss_req_valid_i = 1'b1;
        miss_req_addr_i = 32'h0000_1238;
        settle();
        total_cnt++; if (miss_addr_fifo_wren_o !== 1'b1) $display("FAIL single_wren got %b want 1", miss_addr_fifo_wren_o); else pass_cnt++;
        total_cnt++; if (miss_addr_fifo_wdata_o !== 32'h0000_1238) $display("FAIL single_wdata got %h want 00001238", miss_addr_fifo_wdata_o); else pass_cnt++;
        tick();
        miss_req_valid_i = 1'b0;
        settle();
        total_cnt++; if (mem_arvalid_o !== 1'b1) $display("FAIL single_arvalid got %b want 1", mem_arvalid_o); else pass_cnt++;
        total_cnt++; if (mem_araddr_o !== EXP_ADDR_1238) $display("FAIL single_araddr got %h want %h", mem_araddr_o, EXP_ADDR_1238); else pass_cnt++;
        total_cnt++; if (mem_arburst_o !== EXP_BURST) $display("FAIL single_arburst got %b want %b", mem_arburst_o, EXP_BURST); else pass_cnt++;
        total_cnt++; if (mem_arlen_o !== 4'd7) $display("FAIL single_arlen got %0d want 7", mem_arlen_o); else pass_cnt++;
        total_cnt++; if (mem_arsize_o !== 3'd3) $display("FAIL single_arsize got %0d want 3", mem_arsize_o); else pass_cnt++;
        total_cnt++; if (outstanding_o !== 3'd1) $display("FAIL single_outstanding got %0d want 1", outstanding_o); else pass_cnt++;
        total_cnt++; if (miss_req_ready_o !== 1'b0) $display("FAIL single_ready_in_issue got %b want 0", miss_req_ready_o); else pass_cnt++;
        tick();
        total_cnt++; if (mem_arvalid_o !== 1'b0) $display("FAIL single_arvalid_drop got %b want 0", mem_arvalid_o); else pass_cnt++;
        total_cnt++; if (idle_o !== 1'b0) $display("FAIL single_idle_busy got %b want 0", idle_o); else pass_cnt++;
        mem_rvalid_i = 1'b1;
        mem_rready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_rlast_i = (i == 7);
            settle();
            if (i == 7) begin
                total_cnt++; if (outstanding_o !== 3'd1) $display("FAIL single_before_last got %0d want 1", outstanding_o); else pass_cnt++;
            end
            tick();
        end
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i = 1'b0;
        settle();
        total_cnt++; if (outstanding_o !== 3'd0) $display("FAIL single_done_outstanding got %0d want 0", outstanding_o); else pass_cnt++;
        total_cnt++; if (idle_o !== 1'b1) $display("FAIL single_done_idle got %b want 1", idle_o); else pass_cnt++;
        total_cnt++; if (err_o !== 1'b0) $display("FAIL single_err got %b want 0", err_o); else pass_cnt++;
    endtask

    task automatic test_limit();
        do_reset();
        mem_arready_i = 1'b1;
        miss_req_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            miss_req_addr_i = 32'h0001_0000 + 32'(k) * 32'h40;
            settle();
            total_cnt++; if (miss_req_ready_o !== 1'b1) $display("FAIL limit_ready_%0d got %b want 1", k, miss_req_ready_o); else pass_cnt++;
            tick();
            tick();
        end
        miss_req_addr_i = 32'h0002_0000;
        settle();
        total_cnt++; if (miss_req_ready_o !== 1'b0) $display("FAIL limit_fifth_ready got %b want 0", miss_req_ready_o); else pass_cnt++;
        total_cnt++; if (miss_addr_fifo_wren_o !== 1'b0) $display("FAIL limit_fifth_wren got %b want 0", miss_addr_fifo_wren_o); else pass_cnt++;
        total_cnt++; if (outstanding_o !== 3'd4) $display("FAIL limit_outstanding got %0d want 4", outstanding_o); else pass_cnt++;
        tick();
        total_cnt++; if (miss_req_ready_o !== 1'b0) $display("FAIL limit_hold_ready got %b want 0", miss_req_ready_o); else pass_cnt++;
        mem_rvalid_i = 1'b1;
        mem_rready_i = 1'b1;
        mem_rlast_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i = 1'b0;
        settle();
        total_cnt++; if (outstanding_o !== 3'd3) $display("FAIL limit_after_rlast got %0d want 3", outstanding_o); else pass_cnt++;
        total_cnt++; if (miss_req_ready_o !== 1'b1) $display("FAIL limit_fifth_accept got %b want 1", miss_req_ready_o); else pass_cnt++;
        tick();
        miss_req_valid_i = 1'b0;
        settle();
        total_cnt++; if (outstanding_o !== 3'd4) $display("FAIL limit_refill got %0d want 4", outstanding_o); else pass_cnt++;
    endtask

    task automatic test_fifo_full();
        do_reset();
        mem_arready_i = 1'b1;
        miss_addr_fifo_full_i = 1'b1;
        miss_req_valid_i = 1'b1;
        miss_req_addr_i = 32'hABCD_0040;
        settle();
        total_cnt++; if (miss_req_ready_o !== 1'b0) $display("FAIL full_ready got %b want 0", miss_req_ready_o); else pass_cnt++;
        total_cnt++; if (miss_addr_fifo_wren_o !== 1'b0) $display("FAIL full_wren got %b want 0", miss_addr_fifo_wren_o); else pass_cnt++;
        tick();
        total_cnt++; if (outstanding_o !== 3'd0) $display("FAIL full_outstanding got %0d want 0", outstanding_o); else pass_cnt++;
        total_cnt++; if (mem_arvalid_o !== 1'b0) $display("FAIL full_arvalid got %b want 0", mem_arvalid_o); else pass_cnt++;
        miss_addr_fifo_full_i = 1'b0;
        settle();
        total_cnt++; if (miss_addr_fifo_wren_o !== 1'b1) $display("FAIL full_release_wren got %b want 1", miss_addr_fifo_wren_o); else pass_cnt++;
        tick();
        miss_req_valid_i = 1'b0;
        settle();
        total_cnt++; if (outstanding_o !== 3'd1) $display("FAIL full_release_outstanding got %0d want 1", outstanding_o); else pass_cnt++;
        total_cnt++; if (mem_arvalid_o !== 1'b1) $display("FAIL full_release_arvalid got %b want 1", mem_arvalid_o); else pass_cnt++;
    endtask

    task automatic test_ar_backpressure();
        do_reset();
        mem_arready_i = 1'b0;
        miss_req_valid_i = 1'b1;
        miss_req_addr_i = 32'h8000_0FF8;
        tick();
        miss_req_valid_i = 1'b0;
        miss_req_addr_i = 32'h0;
        for (int c = 0; c < 3; c++) begin
            settle();
            total_cnt++; if (mem_arvalid_o !== 1'b1) $display("FAIL bp_arvalid_%0d got %b want 1", c, mem_arvalid_o); else pass_cnt++;
            total_cnt++; if (mem_araddr_o !== EXP_ADDR_0FF8) $display("FAIL bp_araddr_%0d got %h want %h", c, mem_araddr_o, EXP_ADDR_0FF8); else pass_cnt++;
            total_cnt++; if (miss_req_ready_o !== 1'b0) $display("FAIL bp_ready_%0d got %b want 0", c, miss_req_ready_o); else pass_cnt++;
            tick();
        end
        mem_arready_i = 1'b1;
        settle();
        total_cnt++; if (mem_arvalid_o !== 1'b1) $display("FAIL bp_handshake_arvalid got %b want 1", mem_arvalid_o); else pass_cnt++;
        tick();
        mem_arready_i = 1'b0;
        settle();
        total_cnt++; if (mem_arvalid_o !== 1'b0) $display("FAIL bp_done_arvalid got %b want 0", mem_arvalid_o); else pass_cnt++;
        total_cnt++; if (miss_req_ready_o !== 1'b1) $display("FAIL bp_done_ready got %b want 1", miss_req_ready_o); else pass_cnt++;
        total_cnt++; if (outstanding_o !== 3'd1) $display("FAIL bp_done_outstanding got %0d want 1", outstanding_o); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        mem_arready_i = 1'b1;
        miss_req_valid_i = 1'b1;
        miss_req_addr_i = 32'h0000_0100;
        tick();
        tick();
        miss_req_addr_i = 32'h0000_0200;
        tick();
        tick();
        settle();
        total_cnt++; if (outstanding_o !== 3'd2) $display("FAIL sim_setup got %0d want 2", outstanding_o); else pass_cnt++;
        miss_req_addr_i = 32'h0000_0300;
        mem_rvalid_i = 1'b1;
        mem_rready_i = 1'b1;
        mem_rlast_i = 1'b1;
        settle();
        total_cnt++; if (miss_req_ready_o !== 1'b1) $display("FAIL sim_ready got %b want 1", miss_req_ready_o); else pass_cnt++;
        tick();
        miss_req_valid_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i = 1'b0;
        settle();
        total_cnt++; if (outstanding_o !== 3'd2) $display("FAIL sim_both got %0d want 2", outstanding_o); else pass_cnt++;
        tick();
        mem_rvalid_i = 1'b1;
        mem_rready_i = 1'b1;
        mem_rlast_i = 1'b1;
        tick();
        tick();
        settle();
        total_cnt++; if (outstanding_o !== 3'd0) $display("FAIL sim_drained got %0d want 0", outstanding_o); else pass_cnt++;
        total_cnt++; if (err_o !== 1'b0) $display("FAIL sim_err_before got %b want 0", err_o); else pass_cnt++;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i = 1'b0;
        settle();
        total_cnt++; if (outstanding_o !== 3'd0) $display("FAIL sim_spurious_cnt got %0d want 0", outstanding_o); else pass_cnt++;
        total_cnt++; if (err_o !== 1'b1) $display("FAIL sim_spurious_err got %b want 1", err_o); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (err_o !== 1'b1) $display("FAIL sim_err_sticky got %b want 1", err_o); else pass_cnt++;
    endtask

    task automatic test_reset_in_issue();
        rst_n = 1'b1;
        mem_arready_i = 1'b0;
        miss_req_valid_i = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        total_cnt++; if (err_o !== 1'b0) $display("FAIL rst_clears_err got %b want 0", err_o); else pass_cnt++;
        miss_req_valid_i = 1'b1;
        miss_req_addr_i = 32'h0000_5540;
        tick();
        miss_req_valid_i = 1'b0;
        settle();
        total_cnt++; if (mem_arvalid_o !== 1'b1) $display("FAIL rii_arvalid_before got %b want 1", mem_arvalid_o); else pass_cnt++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_arready_i = 1'b1;
        settle();
        total_cnt++; if (mem_arvalid_o !== 1'b0) $display("FAIL rii_arvalid_after got %b want 0", mem_arvalid_o); else pass_cnt++;
        total_cnt++; if (outstanding_o !== 3'd0) $display("FAIL rii_outstanding got %0d want 0", outstanding_o); else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++; if (mem_arvalid_o !== 1'b0) $display("FAIL rii_no_reissue_%0d got %b want 0", c, mem_arvalid_o); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_limit();
        test_fifo_full();
        test_ar_backpressure();
        test_simultaneous();
        test_reset_in_issue();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
